// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MUL/MULHU/DIVU/REMU sequencer driving an external shared adder
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_sel,
  input  logic [XLEN-1:0] add_sum
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [XLEN-1:0] r_q, r_d, q_q, q_d, m_q, m_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic is_div, calc, co, take, b_zero;
  logic [XLEN-1:0] rsh;
  // r holds hi/rem, q holds lo/quo, m holds mcand/divisor
  assign is_div  = op_q[1];
  assign calc    = state_q == CALC;
  assign rsh     = {r_q[XLEN-2:0], q_q[XLEN-1]};
  assign add_a   = !calc ? '0 : is_div ? rsh : r_q;
  assign add_b   = !calc ? '0 : is_div ? ~m_q : q_q[0] ? m_q : '0;
  assign add_sel = calc & is_div;
  assign co      = (add_a[XLEN-1] & add_b[XLEN-1]) |
                   ((add_a[XLEN-1] ^ add_b[XLEN-1]) & ~add_sum[XLEN-1]);
  assign take    = r_q[XLEN-1] | co;
  assign b_zero  = b == '0;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign result  = done ? (op_q[0] ? r_q : q_q) : res_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        m_d     = op[1] ? b : a;
        r_d     = (op[1] && b_zero) ? a : '0;
        q_d     = !op[1] ? b : b_zero ? '1 : a;
        cnt_d   = '0;
        state_d = (op[1] && b_zero) ? DONE : CALC;
      end
      CALC: begin
        r_d     = is_div ? (take ? add_sum : rsh) : {co, add_sum[XLEN-1:1]};
        q_d     = is_div ? {q_q[XLEN-2:0], take} : {add_sum[0], q_q[XLEN-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(XLEN - 1) ? DONE : CALC;
      end
      DONE: begin
        res_d   = result;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r_q     <= r_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed table-driven checks plus abort/ignore sequences for muldiv_seq
module tb_muldiv_seq;
  logic clk = 0, rst = 1, start = 0, busy, done, add_sel;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, result, add_a, add_b, add_sum;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;
  assign add_sum = add_a + add_b + 32'(add_sel);

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .add_a(add_a), .add_b(add_b), .add_sel(add_sel), .add_sum(add_sum)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, res;
    int          lat;
    logic        sel;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output bit busy_ok,
                        output bit sel_seen);
    res = 'x; lat = -1; busy_ok = 1; sel_seen = 0;
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 0; a = $urandom; b = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      busy_ok &= busy;
      sel_seen |= add_sel;
      if (done) begin
        lat = n; res = result;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    int lat, dones;
    bit bok, sel;
    v[0]  = '{2'b00, 32'd7, 32'd6, 32'h0000002A, 33, 1'b0};
    v[1]  = '{2'b01, 32'd7, 32'd6, 32'h00000000, 33, 1'b0};
    v[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0};
    v[3]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 1'b0};
    v[4]  = '{2'b10, 32'd100, 32'd7, 32'd14, 33, 1'b1};
    v[5]  = '{2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b1};
    v[6]  = '{2'b10, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1'b1};
    v[7]  = '{2'b10, 32'h80000000, 32'h80000001, 32'h00000000, 33, 1'b1};
    v[8]  = '{2'b11, 32'h80000000, 32'h80000001, 32'h80000000, 33, 1'b1};
    v[9]  = '{2'b10, 32'd1234, 32'd0, 32'hFFFFFFFF, 1, 1'b0};
    v[10] = '{2'b11, 32'd1234, 32'd0, 32'd1234, 1, 1'b0};
    v[11] = '{2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 33, 1'b1};

    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_outputs", {busy, done, add_sel, result, add_a, add_b},
        {3'b000, 32'h0, 32'h0, 32'h0});

    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, res, lat, bok, sel);
      chk($sformatf("v%0d_result", i), res, v[i].res);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_busy", i), bok, 1);
      chk($sformatf("v%0d_add_sel_seen", i), sel, v[i].sel);
      @(negedge clk);
      chk($sformatf("v%0d_hold", i), {busy, done, result}, {2'b00, v[i].res});
    end

    // DIVU 100/7 with ignored MUL requests mid-op and in the done cycle
    @(negedge clk);
    start = 1; op = 2'b10; a = 100; b = 7;
    @(posedge clk);
    #1 start = 0;
    dones = 0; lat = -1; res = 'x;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      start = 0;
      if (done) begin dones++; lat = n; res = result; end
      if (n == 10 || n == 33) begin start = 1; op = 2'b00; a = 3; b = 3; end
    end
    @(negedge clk);
    start = 0;
    chk("ign_busy_after", {busy, done}, 2'b00);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ign_latency", lat, 33);
    chk("ign_result", res, 14);
    chk("ign_done_count", dones, 1);
    chk("ign_result_held", result, 14);

    // MUL 5*5 aborted by reset at cycle 15
    @(negedge clk);
    start = 1; op = 2'b00; a = 5; b = 5;
    @(posedge clk);
    #1 start = 0;
    dones = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_outputs", {busy, done, add_sel, result, add_a, add_b},
        {3'b000, 32'h0, 32'h0, 32'h0});
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_op(2'b00, 32'd5, 32'd5, res, lat, bok, sel);
    chk("after_abort_result", res, 25);
    chk("after_abort_latency", lat, 33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative unsigned multiply/divide controller for the M-extension subset MUL, MULHU, DIVU and REMU.
- Owns no arithmetic of its own. It sequences the shared 32-bit adder/subtractor through a dedicated port group (add_a/add_b/add_sel/add_sum), performing one add or trial-subtract per clock.
- Sits beside the ALU in EX and stalls the pipeline via busy.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  operation request; sampled only while busy=0
- op  in  2  00=MUL (low word), 01=MULHU (high word), 10=DIVU (quotient), 11=REMU (remainder)
- a  in  32  multiplicand / dividend; captured on an accepted start
- b  in  32  multiplier / divisor; captured on an accepted start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse; result is valid in that cycle
- result  out  32  result; held after done until the next accepted start
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B (controller supplies ~divisor when subtracting)
- add_sel  out  1  adder carry-in (1 = subtract)
- add_sum  in  32  adder output, defined as add_a + add_b + add_sel mod 2^32, combinational

Behaviour:
- Reset values: busy=0, done=0, result=0, add_a=0, add_b=0, add_sel=0. FSM in IDLE, counter=0, internal registers cleared.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - start=1 latches op, a and b.
  - If op[1]=1 and b=0, go to DONE directly (divide-by-zero fast path).
  - Otherwise go to CALC with counter=0.
- CALC runs exactly 32 cycles (counter 0..31), then goes to DONE.
- DONE lasts one cycle: done=1, busy=1, result updated. Next state is IDLE.
- Latency: start sampled in cycle 0 -> done in cycle 33. Fast path -> done in cycle 1.
- A start arriving while busy=1 is ignored (not queued). A start in the same cycle as done is also ignored. A start arriving in the cycle after done is accepted.
- Adder carry-out, derived internally from the port data: co = (a31&b31) | ((a31^b31)&~s31), where a31=add_a[31], b31=add_b[31], s31=add_sum[31].
- Multiply (shift-add):
  - Registers: hi=0, lo=b, mcand=a.
  - Each CALC cycle drives add_a=hi, add_b=(lo[0] ? mcand : 0), add_sel=0.
  - Then {hi,lo} <= {co, add_sum, lo} >> 1. When lo[0]=0, co is 0 by construction.
  - MUL result = lo. MULHU result = hi.
- Divide (restoring):
  - Registers: rem=0, quo=a, dvsr=b.
  - Each CALC cycle forms {rtop, rsh} = {rem, quo[31]} (33 bits).
  - Drives add_a=rsh, add_b=~dvsr, add_sel=1.
  - If rtop|co: rem<=add_sum, qbit=1. Else rem<=rsh, qbit=0.
  - quo <= {quo[30:0], qbit}.
  - DIVU result = quo. REMU result = rem.
- Divide by zero (RISC-V semantics): DIVU result = 0xFFFFFFFF, REMU result = a. No adder activity.
- The adder port group is driven to 0/0/0 in IDLE and DONE.
- A synchronous rst asserted mid-operation aborts it. The block returns to reset values next edge with no done pulse.
- Operands a/b may change freely after the start cycle without effect.

Test Plan:
- MUL a=7, b=6 -> done in cycle 33, result=0x0000002A. Same operands with op=MULHU -> result=0x00000000.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. MUL with the same operands -> result=0x00000001.
- DIVU a=100, b=7 -> result=14. REMU same operands -> result=2. DIVU a=0xFFFFFFFF, b=1 -> result=0xFFFFFFFF. DIVU a=0x80000000, b=0x80000001 -> result=0.
- DIVU a=1234, b=0 -> done in cycle 1, result=0xFFFFFFFF. REMU a=1234, b=0 -> result=1234. add_sel stays 0 throughout.
- start DIVU 100/7, then pulse start with MUL 3*3 at cycle 10 and again in the done cycle -> single done at cycle 33 with result=14. Second request ignored; busy=0 at cycle 34.
- start MUL 5*5, assert rst at cycle 15 for one cycle -> all outputs 0 from cycle 16, no done. A fresh MUL 5*5 started after reset -> result=25.
